seg_conv_sched: RTL

- Time-shares one registered binary-to-7-segment converter between two digit requesters (digit 0 = ones, digit 1 = tens) on the Go Board.
- Arbitrates update requests round-robin and drives the shared converter input.
- Captures the converter result into per-digit, active-low segment registers that drive the display pins directly.
- Issues periodic refresh conversions so the display always matches current digit values.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_rr_arb2.sv | 33 +++
 rtl/seg_conv_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the time-shared 7-segment converter scheduler.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int unsigned NUM_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  localparam logic DIG0 = 1'b0;
  localparam logic DIG1 = 1'b1;

endpackage

// File: rtl/seg_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational; the pointer
// moves to the other requester only when the caller reports an accepted grant.
module seg_rr_arb2 (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  input  logic       i_accept_idx,
  output logic [1:0] o_gnt_c
);

  logic r_ptr;

  // Pointer favours the requester that was not served last.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= ~i_accept_idx;
    end
  end

  // One-hot grant; the pointer breaks ties.
  always_comb begin
    o_gnt_c = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt_c[r_ptr] = 1'b1;
    end else begin
      o_gnt_c = i_req;
    end
  end

endmodule

// File: rtl/seg_conv_sched.sv
// Time-shares one registered binary-to-7-segment converter between two digits.
// Optional leading-zero blanking of digit 1: define SEG_CONV_SCHED_BLANK_EN.
module seg_conv_sched
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_Req,
  input  logic [3:0] i_Digit0,
  input  logic [3:0] i_Digit1,
  output logic [1:0] o_Ack,
  output logic [3:0] o_Conv_Num,
  input  logic [6:0] i_Conv_Seg,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2,
  output logic       o_Busy
);

  localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic REFRESH_EN = (REFRESH_CYCLES != 0);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         w_elig;
  logic [1:0]         w_gnt;
  logic               w_grant;
  logic               w_sel;
  logic               w_is_ref;
  logic               w_blank;
  logic               w_capture;
  logic               w_accept;
  logic               w_wrap;
  logic [NUM_W-1:0]   w_sel_val;

  logic               r_dig;
  logic               r_is_ref;
  logic               r_blank;
  logic               r_busy;
  logic [1:0]         r_ack;
  logic [1:0]         r_pend;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_W-1:0]   r_conv_num;
  logic [SEG_W-1:0]   r_seg1;
  logic [SEG_W-1:0]   r_seg2;

  // A requester still high during its own ack cycle is not eligible again.
  assign w_elig    = i_Req & ~r_ack;
  assign w_capture = (r_state == CAPTURE);
  assign w_accept  = w_capture && !r_is_ref;
  assign w_sel_val = w_sel ? i_Digit1 : i_Digit0;
  assign w_wrap    = REFRESH_EN && (r_cnt == CNT_MAX);

  seg_rr_arb2 u_arb (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_req        (w_elig),
    .i_accept     (w_accept),
    .i_accept_idx (r_dig),
    .o_gnt_c      (w_gnt)
  );

  // State register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and grant selection: external requests outrank refresh.
  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_sel    = DIG0;
    w_is_ref = 1'b0;
    w_blank  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_grant = 1'b1;
          w_sel   = w_gnt[1];
        end else if (r_pend[0]) begin
          w_grant  = 1'b1;
          w_sel    = DIG0;
          w_is_ref = 1'b1;
        end else if (r_pend[1]) begin
          w_grant  = 1'b1;
          w_sel    = DIG1;
          w_is_ref = 1'b1;
        end
        if (w_grant) begin
`ifdef SEG_CONV_SCHED_BLANK_EN
          w_blank = (w_sel == DIG1) && (i_Digit1 == 4'd0);
`endif
          w_next = w_blank ? CAPTURE : ISSUE;
        end
      end
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Busy mirrors "not IDLE" as a registered output.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
    end
  end

  // Record the grant and launch the converter (skipped for a blanked digit).
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_dig      <= DIG0;
      r_is_ref   <= 1'b0;
      r_blank    <= 1'b0;
      r_conv_num <= '0;
    end else if (w_grant) begin
      r_dig    <= w_sel;
      r_is_ref <= w_is_ref;
      r_blank  <= w_blank;
      if (!w_blank) begin
        r_conv_num <= w_sel_val;
      end
    end
  end

  // Capture converter result into the active-low pins and pulse the ack.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_seg1 <= SEG_OFF;
      r_seg2 <= SEG_OFF;
      r_ack  <= 2'b00;
    end else begin
      r_ack <= 2'b00;
      if (w_capture) begin
        if (r_dig == DIG1) begin
          r_seg1 <= r_blank ? SEG_OFF : ~i_Conv_Seg;
        end else begin
          r_seg2 <= ~i_Conv_Seg;
        end
        if (!r_is_ref) begin
          r_ack[r_dig] <= 1'b1;
        end
      end
    end
  end

  // Free-running refresh timer; a wrap marks both digits stale.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_cnt  <= '0;
      r_pend <= 2'b00;
    end else begin
      if (!REFRESH_EN || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture && r_is_ref) begin
        r_pend[r_dig] <= 1'b0;
      end
      if (w_wrap) begin
        r_pend <= 2'b11;
      end
    end
  end

  assign o_Ack      = r_ack;
  assign o_Conv_Num = r_conv_num;
  assign o_Segment1 = r_seg1;
  assign o_Segment2 = r_seg2;
  assign o_Busy     = r_busy;

endmodule
